// File: rtl/uart_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_pkg : shared UART constants and FSM encodings  |  Rev 1.0
// ------------------------------------------------------------------
package uart_pkg;

  localparam int c_clk_freq     = 50_000_000;
  localparam int c_baudrate     = 115_200;
  localparam int c_clks_per_bit = c_clk_freq / c_baudrate;

  // Numbering is shared with the transmitter.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_if : serial line and received-byte outputs  |  Rev 1.0
// ------------------------------------------------------------------
interface uart_rx_if;

  logic       serial_in;
  logic [7:0] data_out;
  logic       Rx_Done;
  logic       Rx_Active;
  logic       Frame_Err;

  modport master (
    output serial_in,
    input  data_out, Rx_Done, Rx_Active, Frame_Err
  );

  modport slave (
    input  serial_in,
    output data_out, Rx_Done, Rx_Active, Frame_Err
  );

endinterface
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_sync : two-flop synchroniser, parameterised reset  |  Rev 1.0
// ------------------------------------------------------------------
module uart_sync #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
    end
  end

  assign sync_out = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx : 8N1 UART receiver, mid-bit sampling, 1-cycle strobes  |  Rev 1.0
// ------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_freq     = c_clk_freq,
  parameter int baudrate     = c_baudrate,
  parameter int clks_per_bit = clk_freq / baudrate,
  parameter int half_bit     = (clks_per_bit - 1) / 2
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave rx
);

  localparam logic [8:0] c_bit_last = 9'(clks_per_bit - 1);
  localparam logic [8:0] c_half     = 9'(half_bit);

  uart_state_t r_state, w_state_nxt;
  logic [8:0]  r_baud_cnt, w_baud_nxt;
  logic [2:0]  r_bit_idx, w_idx_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [7:0]  r_data, w_data_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic        r_active, w_active_nxt;
  logic        w_rx_s;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (rx.serial_in),
    .sync_out (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_idx  <= w_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_data     <= w_data_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_active   <= w_active_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_baud_nxt   = r_baud_cnt;
    w_idx_nxt    = r_bit_idx;
    w_shift_nxt  = r_shift;
    w_data_nxt   = r_data;
    w_done_nxt   = r_done;
    w_err_nxt    = r_err;
    w_active_nxt = r_active;

    unique case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        w_idx_nxt  = '0;
        if (!w_rx_s) begin
          w_state_nxt  = START;
          w_active_nxt = 1'b1;
        end
      end
      START: begin
        // A start bit that is no longer low at mid-bit is a glitch.
        if (r_baud_cnt == c_half) begin
          if (!w_rx_s) begin
            w_baud_nxt  = '0;
            w_state_nxt = DATA;
          end else begin
            w_state_nxt  = IDLE;
            w_active_nxt = 1'b0;
          end
        end else begin
          w_baud_nxt = r_baud_cnt + 9'd1;
        end
      end
      DATA: begin
        if (r_baud_cnt == c_bit_last) begin
          w_shift_nxt[r_bit_idx] = w_rx_s;
          w_baud_nxt             = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud_cnt + 9'd1;
        end
      end
      STOP: begin
        if (r_baud_cnt == c_bit_last) begin
          if (w_rx_s) begin
            w_data_nxt = r_shift;
            w_done_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
          w_state_nxt = CLEANUP;
        end else begin
          w_baud_nxt = r_baud_cnt + 9'd1;
        end
      end
      CLEANUP: begin
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_active_nxt = 1'b0;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign rx.data_out  = r_data;
  assign rx.Rx_Done   = r_done;
  assign rx.Rx_Active = r_active;
  assign rx.Frame_Err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_uart_rx : randomized frame stimulus against a frame-level model  |  Rev 1.0
// ------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB  = 434;
  localparam int HALF = (CPB - 1) / 2;
  localparam int LAT  = 2 + 1 + (HALF + 1) + 9 * CPB;

  typedef struct {
    bit err;
    int data;
    int cyc;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   model_last = 0;
  ev_t  got_q[$];
  ev_t  exp_q[$];

  uart_rx_if rx_if ();

  uart_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    ev_t x;
    if (rx_if.Rx_Done) begin
      x.err = 1'b0; x.data = int'(rx_if.data_out); x.cyc = cyc;
      got_q.push_back(x);
    end
    if (rx_if.Frame_Err) begin
      x.err = 1'b1; x.data = int'(rx_if.data_out); x.cyc = cyc;
      got_q.push_back(x);
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Drives one frame starting at the current negedge; leaves the line idle after the stop bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int period);
    ev_t x;
    int  e;
    bit  act_ok;
    rx_if.serial_in = 1'b0;
    e      = cyc;
    act_ok = 1'b1;
    x.err  = !stop_ok;
    x.data = stop_ok ? int'(b) : model_last;
    x.cyc  = (period == CPB) ? e + LAT : -1;
    exp_q.push_back(x);
    if (stop_ok) model_last = int'(b);
    for (int i = 0; i < 10; i++) begin
      repeat (period) @(negedge clk);
      if (i < 9) act_ok &= rx_if.Rx_Active;
      rx_if.serial_in = (i < 8) ? b[i] : ((i == 8) ? stop_ok : 1'b1);
    end
    check_val("active_in_frame", int'(act_ok), 1);
  endtask

  task automatic compare_events(input string tag);
    int lat;
    check_val({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_val({tag, "_kind"}, int'(got_q[i].err), int'(exp_q[i].err));
      check_val({tag, "_data"}, got_q[i].data, exp_q[i].data);
      if (exp_q[i].cyc >= 0) begin
        lat = got_q[i].cyc - exp_q[i].cyc;
        check_val({tag, "_latency_offset"}, (lat >= -1 && lat <= 1) ? 0 : lat, 0);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_data_out"},  int'(rx_if.data_out), 0);
    check_val({tag, "_rx_done"},   int'(rx_if.Rx_Done), 0);
    check_val({tag, "_rx_active"}, int'(rx_if.Rx_Active), 0);
    check_val({tag, "_frame_err"}, int'(rx_if.Frame_Err), 0);
  endtask

  initial begin : stim
    logic [7:0] rb;
    rx_if.serial_in = 1'b1;
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (10000) @(negedge clk);
    compare_events("idle");

    send_frame(8'hA5, 1'b1, CPB);
    repeat (20) @(negedge clk);
    check_val("a5_active_after", int'(rx_if.Rx_Active), 0);
    compare_events("a5");

    send_frame(8'h00, 1'b1, CPB);
    send_frame(8'hFF, 1'b1, CPB);
    send_frame(8'h3C, 1'b1, CPB);
    repeat (20) @(negedge clk);
    compare_events("b2b");

    rx_if.serial_in = 1'b0;
    repeat (50) @(negedge clk);
    check_val("glitch_active_during", int'(rx_if.Rx_Active), 1);
    repeat (50) @(negedge clk);
    rx_if.serial_in = 1'b1;
    repeat (300) @(negedge clk);
    check_val("glitch_active_after", int'(rx_if.Rx_Active), 0);
    compare_events("glitch");

    send_frame(8'h5A, 1'b0, CPB);
    repeat (20) @(negedge clk);
    compare_events("frame_err");

    // Abort mid data bit 4 with a synchronous reset.
    rb = 8'($urandom);
    rx_if.serial_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (CPB) @(negedge clk);
      rx_if.serial_in = rb[i];
    end
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    rx_if.serial_in = 1'b1;
    rst_n = 1'b1;
    model_last = 0;
    repeat (1000) @(negedge clk);
    compare_events("mid_reset");

    send_frame(8'h81, 1'b1, CPB);
    repeat (20) @(negedge clk);
    compare_events("post_reset");

    for (int n = 0; n < 3; n++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      send_frame(8'($urandom), ($urandom_range(0, 3) != 0), int'($urandom_range(426, 442)));
    end
    repeat (20) @(negedge clk);
    compare_events("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
